// File: rtl/ulpi_rx_framer_pkg.sv
// Shared definitions for the ULPI receive framer: FSM encoding, RX CMD field
// positions and the layout of the trailing status byte.
package ulpi_rx_framer_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RECV,
    S_EMIT_SYNC,
    S_EMIT_LEN_H,
    S_EMIT_LEN_L,
    S_EMIT_DATA,
    S_EMIT_STAT
  } state_t;

  // RX CMD fields
  localparam int         LS_LO     = 0;
  localparam int         LS_HI     = 1;
  localparam int         RXACT_BIT = 4;
  localparam int         RXEV_LO   = 4;
  localparam int         RXEV_HI   = 5;
  localparam logic [1:0] RXEV_ERR  = 2'b11;

  // Status byte: {trunc, err, drops[5:0]}
  localparam int                 ST_TRUNC_BIT = 7;
  localparam int                 ST_ERR_BIT   = 6;
  localparam int                 DROPS_W      = 6;
  localparam logic [DROPS_W-1:0] DROPS_MAX    = '1;

  function automatic logic [7:0] status_byte(input logic trunc, input logic err,
                                             input logic [DROPS_W-1:0] drops);
    logic [7:0] s;
    s               = '0;
    s[ST_TRUNC_BIT] = trunc;
    s[ST_ERR_BIT]   = err;
    s[DROPS_W-1:0]  = drops;
    return s;
  endfunction

endpackage

// File: rtl/ulpi_pkt_ram.sv
// Simple dual-port packet buffer: one write port, one registered read port,
// shaped so it maps onto a block RAM.
module ulpi_pkt_ram #(
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [7:0]        wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [7:0]        rdata
);

  logic [7:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    rdata <= mem[raddr];
  end

endmodule

// File: rtl/ulpi_rx_framer.sv
// Passive ULPI RX framer: stores each PHY-driven packet, then replays it as
// SYNC, 16-bit length, payload and a status byte on a valid/ready stream.
module ulpi_rx_framer
  import ulpi_rx_framer_pkg::*;
#(
  parameter int         ADDR_W = 11,
  parameter logic [7:0] SYNC   = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       DIR,
  input  logic       NXT,
  input  logic [7:0] DATA_I,
  output logic [7:0] O_DATA,
  output logic       O_VALID,
  input  logic       I_READY,
  output logic [1:0] LINESTATE,
  output logic       RX_ACTIVE,
  output logic       BUSY
);

  localparam logic [ADDR_W:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

  logic              dir_r, nxt_r, dir_q;
  logic [7:0]        data_r;
  logic              bus_own, rx_cmd, rx_byte, dir_fall, pkt_end, cmd_err;

  state_t            state, state_n;
  logic [ADDR_W:0]   len, len_n, cnt, cnt_n;
  logic              trunc, trunc_n, err, err_n;
  logic              dropping, dropping_n, stat_loaded, stat_loaded_n;
  logic [DROPS_W-1:0] drops, drops_n;
  logic              valid_n;
  logic [7:0]        odata_n;
  logic              emitting, out_free, new_drop, we;
  logic [ADDR_W-1:0] waddr;
  logic [7:0]        rdata;
  logic [15:0]       len16;

  always_ff @(posedge clk) begin
    if (rst) begin
      dir_r  <= 1'b0;
      nxt_r  <= 1'b0;
      dir_q  <= 1'b0;
      data_r <= '0;
    end else begin
      dir_r  <= DIR;
      nxt_r  <= NXT;
      dir_q  <= dir_r;
      data_r <= DATA_I;
    end
  end

  // A DIR edge in either direction is a turnaround cycle and carries nothing.
  assign bus_own  = dir_r & dir_q;
  assign rx_cmd   = bus_own & ~nxt_r;
  assign rx_byte  = bus_own & nxt_r;
  assign dir_fall = ~dir_r & dir_q;
  assign pkt_end  = dir_fall | (rx_cmd & ~data_r[RXACT_BIT]);
  assign cmd_err  = rx_cmd & (data_r[RXEV_HI:RXEV_LO] == RXEV_ERR);

  always_ff @(posedge clk) begin
    if (rst) begin
      LINESTATE <= 2'b00;
      RX_ACTIVE <= 1'b0;
    end else if (rx_cmd) begin
      LINESTATE <= data_r[LS_HI:LS_LO];
      RX_ACTIVE <= data_r[RXACT_BIT];
    end
  end

  assign emitting = (state != S_IDLE) && (state != S_RECV);
  assign out_free = ~O_VALID | I_READY;
  assign new_drop = rx_byte & emitting & ~dropping;
  assign len16    = 16'(len);
  assign BUSY     = (state != S_IDLE);

  // Read address tracks the next emit count so rdata always holds buf[cnt].
  ulpi_pkt_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (we),
    .waddr (waddr),
    .wdata (data_r),
    .raddr (cnt_n[ADDR_W-1:0]),
    .rdata (rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n       = state;
    len_n         = len;
    cnt_n         = cnt;
    trunc_n       = trunc;
    err_n         = err;
    drops_n       = drops;
    dropping_n    = dropping;
    stat_loaded_n = stat_loaded;
    valid_n       = O_VALID;
    odata_n       = O_DATA;
    we            = 1'b0;
    waddr         = len[ADDR_W-1:0];

    if (out_free) valid_n = 1'b0;

    // A packet seen while emitting is discarded whole, counted once.
    if (rx_byte & emitting) dropping_n = 1'b1;
    else if (pkt_end)       dropping_n = 1'b0;
    if (new_drop && drops != DROPS_MAX) drops_n = drops + 1'b1;

    unique case (state)
      S_IDLE: begin
        if (rx_byte & ~dropping) begin
          we      = 1'b1;
          waddr   = '0;
          len_n   = {{ADDR_W{1'b0}}, 1'b1};
          state_n = S_RECV;
        end
      end
      S_RECV: begin
        if (rx_byte) begin
          if (len == MAX_LEN) begin
            trunc_n = 1'b1;
          end else begin
            we    = 1'b1;
            len_n = len + 1'b1;
          end
        end
        if (cmd_err) err_n = 1'b1;
        if (pkt_end) begin
          cnt_n   = '0;
          state_n = S_EMIT_SYNC;
        end
      end
      S_EMIT_SYNC: begin
        if (out_free) begin
          valid_n = 1'b1;
          odata_n = SYNC;
          state_n = S_EMIT_LEN_H;
        end
      end
      S_EMIT_LEN_H: begin
        if (out_free) begin
          valid_n = 1'b1;
          odata_n = len16[15:8];
          state_n = S_EMIT_LEN_L;
        end
      end
      S_EMIT_LEN_L: begin
        if (out_free) begin
          valid_n = 1'b1;
          odata_n = len16[7:0];
          state_n = S_EMIT_DATA;
        end
      end
      S_EMIT_DATA: begin
        if (out_free) begin
          valid_n = 1'b1;
          odata_n = rdata;
          cnt_n   = cnt + 1'b1;
          if ((cnt + 1'b1) == len) state_n = S_EMIT_STAT;
        end
      end
      S_EMIT_STAT: begin
        if (!stat_loaded) begin
          if (out_free) begin
            valid_n       = 1'b1;
            odata_n       = status_byte(trunc, err, drops);
            stat_loaded_n = 1'b1;
          end
        end else if (O_VALID & I_READY) begin
          // A drop landing on the accept cycle belongs to the next frame.
          stat_loaded_n = 1'b0;
          trunc_n       = 1'b0;
          err_n         = 1'b0;
          len_n         = '0;
          drops_n       = new_drop ? {{(DROPS_W-1){1'b0}}, 1'b1} : '0;
          state_n       = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      len         <= '0;
      cnt         <= '0;
      trunc       <= 1'b0;
      err         <= 1'b0;
      drops       <= '0;
      dropping    <= 1'b0;
      stat_loaded <= 1'b0;
      O_VALID     <= 1'b0;
      O_DATA      <= '0;
    end else begin
      len         <= len_n;
      cnt         <= cnt_n;
      trunc       <= trunc_n;
      err         <= err_n;
      drops       <= drops_n;
      dropping    <= dropping_n;
      stat_loaded <= stat_loaded_n;
      O_VALID     <= valid_n;
      O_DATA      <= odata_n;
    end
  end

endmodule

// File: tb/tb_ulpi_rx_framer.sv
// Bench for ulpi_rx_framer: directed scenarios plus randomized packets,
// checked against a frame-level model of what each packet should produce.
module tb_ulpi_rx_framer;

  localparam int AW   = 4;
  localparam int MAXL = 1 << AW;

  logic       clk = 1'b0;
  logic       rst, DIR, NXT, I_READY;
  logic [7:0] DATA_I, O_DATA;
  logic       O_VALID, RX_ACTIVE, BUSY;
  logic [1:0] LINESTATE;

  ulpi_rx_framer #(.ADDR_W(AW), .SYNC(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .DIR       (DIR),
    .NXT       (NXT),
    .DATA_I    (DATA_I),
    .O_DATA    (O_DATA),
    .O_VALID   (O_VALID),
    .I_READY   (I_READY),
    .LINESTATE (LINESTATE),
    .RX_ACTIVE (RX_ACTIVE),
    .BUSY      (BUSY)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int errors  = 0;
  int cyc     = 0;
  int rmode   = 0;   // 0 ready high, 1 toggle, 2 random, 3 ready low
  logic [1:0] ls_exp = 2'b00;
  logic       ra_exp = 1'b0;

  logic [7:0] rxq[$];
  int         stampq[$];
  logic       pv = 1'b0, pr = 1'b0, prst = 1'b1;
  logic [7:0] pd = 8'h00;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Consumer side: record accepted bytes and police the hold rule.
  always @(negedge clk) begin
    if (pv && !pr && !prst && !rst) begin
      chk("hold_valid", {31'd0, O_VALID}, 32'd1);
      chk("hold_data", {24'd0, O_DATA}, {24'd0, pd});
    end
    if (O_VALID && I_READY && !rst) begin
      rxq.push_back(O_DATA);
      stampq.push_back(cyc);
    end
    pv   = O_VALID;
    pr   = I_READY;
    pd   = O_DATA;
    prst = rst;
  end

  initial begin
    logic tog;
    tog     = 1'b0;
    I_READY = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rmode)
        0:       I_READY = 1'b1;
        1:       begin tog = ~tog; I_READY = tog; end
        2:       I_READY = 1'($urandom_range(0, 1));
        default: I_READY = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic pins(input logic d, input logic n, input logic [7:0] x);
    DIR    = d;
    NXT    = n;
    DATA_I = x;
    @(posedge clk);
    #1;
  endtask

  // An RX CMD on an owned (non-turnaround) cycle.
  task automatic cmd(input logic [7:0] x);
    ls_exp = x[1:0];
    ra_exp = x[4];
    pins(1'b1, 1'b0, x);
  endtask

  task automatic idle(input int n);
    repeat (n) pins(1'b0, 1'($urandom_range(0, 1)), 8'($urandom));
  endtask

  function automatic logic [7:0] rcmd(input logic [1:0] ev);
    logic [7:0] r;
    r      = 8'($urandom);
    r[5:4] = ev;
    return r;
  endfunction

  // end_cmd 8'hFF means end the packet by releasing DIR.
  task automatic send_pkt(input logic [7:0] d[$], input int err_pos, input logic [7:0] err_cmd,
                          input logic [7:0] lead, input logic [7:0] end_cmd, input bit rnd,
                          output int end_cyc);
    pins(1'b1, rnd ? 1'($urandom_range(0, 1)) : 1'b0, rnd ? 8'($urandom) : 8'h00);
    cmd(lead);
    foreach (d[i]) begin
      if (rnd && $urandom_range(0, 3) == 0) cmd(rcmd(2'b01));
      pins(1'b1, 1'b1, d[i]);
      if (i == err_pos) cmd(err_cmd);
    end
    end_cyc = cyc;
    if (end_cmd != 8'hFF) cmd(end_cmd);
    pins(1'b0, 1'b0, 8'h00);
  endtask

  task automatic wait_idle(input int maxc);
    int t;
    t = 0;
    @(negedge clk);
    while (BUSY && t < maxc) begin
      @(negedge clk);
      t++;
    end
    chk("idle_timeout", {31'd0, BUSY}, 32'd0);
    @(posedge clk);
    #1;
  endtask

  task automatic expect_frame(input string tag, input logic [7:0] d[$], input bit err,
                              input int drops, input int end_cyc, input bit stamps);
    logic [7:0] e[$];
    int n, len;
    n   = d.size();
    len = (n > MAXL) ? MAXL : n;
    e.push_back(8'hA5);
    e.push_back(8'(len >> 8));
    e.push_back(8'(len));
    for (int i = 0; i < len; i++) e.push_back(d[i]);
    e.push_back({n > MAXL, err, 6'(drops)});
    idle(2);
    wait_idle(400);
    chk({tag, "_size"}, rxq.size(), e.size());
    for (int i = 0; i < e.size() && i < rxq.size(); i++)
      chk($sformatf("%s_b%0d", tag, i), {24'd0, rxq[i]}, {24'd0, e[i]});
    if (stamps && rxq.size() == e.size()) begin
      chk({tag, "_sync_lat"}, stampq[0], end_cyc + 3);
      chk({tag, "_span"}, stampq[stampq.size()-1] - stampq[0], e.size() - 1);
    end
    chk({tag, "_linestate"}, {30'd0, LINESTATE}, {30'd0, ls_exp});
    chk({tag, "_rxactive"}, {31'd0, RX_ACTIVE}, {31'd0, ra_exp});
    rxq.delete();
    stampq.delete();
  endtask

  initial begin
    logic [7:0] pkt[$];
    logic [7:0] endc;
    int ec, n, ep;
    bit e;

    rst = 1'b1; DIR = 1'b0; NXT = 1'b0; DATA_I = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_valid", {31'd0, O_VALID}, 32'd0);
    chk("rst_data", {24'd0, O_DATA}, 32'd0);
    chk("rst_linestate", {30'd0, LINESTATE}, 32'd0);
    chk("rst_rxactive", {31'd0, RX_ACTIVE}, 32'd0);
    chk("rst_busy", {31'd0, BUSY}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    idle(3);

    // Basic packet, consumer always ready: bubble-free stream.
    pkt = '{8'hC3, 8'h01, 8'h02};
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    expect_frame("basic", pkt, 1'b0, 0, ec, 1'b1);

    // Same packet under a toggling ready.
    rmode = 1;
    idle(2);
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    expect_frame("toggle", pkt, 1'b0, 0, ec, 1'b0);

    // Error event mid-packet, ended by an RX CMD.
    rmode = 0;
    idle(2);
    pkt = '{8'h11, 8'h22, 8'h33};
    send_pkt(pkt, 1, 8'h30, 8'h10, 8'h00, 1'b0, ec);
    expect_frame("err", pkt, 1'b1, 0, ec, 1'b1);

    // Oversize packet is truncated to the buffer size.
    pkt.delete();
    for (int i = 0; i < 20; i++) pkt.push_back(8'(8'h40 + i));
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    expect_frame("trunc", pkt, 1'b0, 0, ec, 1'b1);

    // RX CMD-only burst must not produce a frame.
    pins(1'b1, 1'b0, 8'h00);
    cmd(8'h11); cmd(8'h13); cmd(8'h02);
    pins(1'b0, 1'b0, 8'h00);
    repeat (6) begin
      @(negedge clk);
      chk("cmdonly_busy", {31'd0, BUSY}, 32'd0);
    end
    @(posedge clk);
    #1;
    chk("cmdonly_bytes", rxq.size(), 0);
    chk("cmdonly_linestate", {30'd0, LINESTATE}, 32'd2);
    chk("cmdonly_rxactive", {31'd0, RX_ACTIVE}, 32'd0);

    // Packets arriving during a stalled emission are counted as drops.
    rmode = 3;
    idle(2);
    pkt = '{8'hAA, 8'hBB};
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    idle(3);
    repeat (3) begin
      send_pkt('{8'h77}, -1, 8'h00, 8'h10, 8'hFF, 1'b1, ec);
      idle(1);
    end
    rmode = 0;
    expect_frame("drops3", pkt, 1'b0, 3, ec, 1'b0);

    rmode = 3;
    idle(2);
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    idle(3);
    repeat (70) begin
      send_pkt('{8'h66}, -1, 8'h00, 8'h10, 8'hFF, 1'b1, ec);
      idle(1);
    end
    rmode = 0;
    expect_frame("drops_sat", pkt, 1'b0, 63, ec, 1'b0);

    // Reset in the middle of the payload abandons the frame.
    idle(2);
    pkt.delete();
    for (int i = 0; i < 10; i++) pkt.push_back(8'(8'h90 + i));
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    idle(5);
    rst = 1'b1;
    pins(1'b0, 1'b0, 8'h00);
    rst = 1'b0;
    ls_exp = 2'b00;
    ra_exp = 1'b0;
    @(negedge clk);
    chk("midrst_valid", {31'd0, O_VALID}, 32'd0);
    chk("midrst_data", {24'd0, O_DATA}, 32'd0);
    chk("midrst_busy", {31'd0, BUSY}, 32'd0);
    chk("midrst_linestate", {30'd0, LINESTATE}, 32'd0);
    @(posedge clk);
    #1;
    rxq.delete();
    stampq.delete();
    idle(2);
    pkt = '{8'h5A};
    send_pkt(pkt, -1, 8'h00, 8'h10, 8'hFF, 1'b0, ec);
    expect_frame("after_rst", pkt, 1'b0, 0, ec, 1'b1);

    // Randomized packets, one at a time.
    for (int it = 0; it < 40; it++) begin
      n = $urandom_range(1, MAXL + 6);
      pkt.delete();
      for (int i = 0; i < n; i++) pkt.push_back(8'($urandom));
      e     = ($urandom_range(0, 2) == 0);
      ep    = e ? int'($urandom_range(0, n - 1)) : -1;
      rmode = $urandom_range(0, 2);
      endc  = $urandom_range(0, 1) ? rcmd({1'($urandom_range(0, 1)), 1'b0}) : 8'hFF;
      idle(1 + $urandom_range(0, 3));
      send_pkt(pkt, ep, rcmd(2'b11), rcmd($urandom_range(0, 1) ? 2'b11 : 2'b01), endc, 1'b1, ec);
      expect_frame($sformatf("rand%0d", it), pkt, e, 0, ec, rmode == 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
